// File: rtl/axis_pkt_gen_pkg.sv
// axis_pkt_pkg: shared types and helpers for the AXI-Stream packet generator.
// Holds the FSM state enum, the bytes-per-beat helper and the last-beat
// keep-mask function used by axis_keep_mask.

package axis_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pkt_state_e;

    // Widest beat the keep helper supports (1024-bit data).
    localparam int MAX_BYTES = 128;

    function automatic int calc_bytes(input int width);
        return width / 8;
    endfunction

    // Keep mask for the final beat: the low `rem` lanes, or every lane when
    // the packet length is an exact multiple of the beat size.
    function automatic logic [MAX_BYTES-1:0] last_keep(input int rem, input int bytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if ((i < bytes) && ((rem == 0) || (i < rem))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// axis_pkt_gen_if: command channel plus AXIS master channel of the packet
// generator. The master modport is the generator side, slave the consumer.

interface axis_pkt_gen_if
    import axis_pkt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
);
    localparam int BYTES = calc_bytes(WIDTH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_seed;

    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic [BYTES-1:0] m_axis_tkeep;
    logic             m_axis_tlast;

    modport master (
        input  cmd_valid, cmd_len, cmd_seed, m_axis_tready,
        output cmd_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_seed, m_axis_tready,
        input  cmd_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

endinterface

// File: rtl/axis_pkt_gen_keep_mask.sv
// axis_keep_mask: combinational decoder from (length mod BYTES) to the
// contiguous byte-enable mask of the last beat.

module axis_keep_mask
    import axis_pkt_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int REM_W = 2
) (
    input  logic [REM_W-1:0] rem,
    output logic [BYTES-1:0] keep
);

    // Decode the remainder into a lane mask (zero remainder = full beat).
    always_comb begin
        keep = BYTES'(last_keep(int'(rem), BYTES));
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: turns a one-beat command (byte length + seed) into a framed
// AXIS packet. Beat i carries seed + i; tkeep/tlast mark the packet end.
// Optional build macro: AXIS_PKT_GEN_STATS_EN adds stat_pkts/stat_beats.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command with non-zero length
// SEND  | presenting beats 0..N-1, advancing on each handshake
// GAP   | idle spacing of GAP_CYCLES cycles after the tlast handshake

module axis_pkt_gen
    import axis_pkt_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic            aclk,
    input  logic            areset,
    axis_pkt_gen_if.master  axis,
    output logic            busy
`ifdef AXIS_PKT_GEN_STATS_EN
    ,
    output logic [31:0]     stat_pkts,
    output logic [31:0]     stat_beats
`endif
);

    localparam int BYTES = calc_bytes(WIDTH);
    localparam int LOG2B = $clog2(BYTES);
    localparam int REM_W = (LOG2B > 0) ? LOG2B : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    pkt_state_e       state_q, state_nxt;
    logic [LEN_W-1:0] beat_idx_q, beat_idx_nxt;
    logic [LEN_W-1:0] last_idx_q, last_idx_nxt;
    logic [REM_W-1:0] rem_q, rem_nxt;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_nxt;

    logic             tvalid_q, tvalid_nxt;
    logic [WIDTH-1:0] tdata_q, tdata_nxt;
    logic [BYTES-1:0] tkeep_q, tkeep_nxt;
    logic             tlast_q, tlast_nxt;
    logic             cmd_ready_q, cmd_ready_nxt;
    logic             busy_q, busy_nxt;

    logic             cmd_fire;
    logic             beat_fire;
    logic             cmd_nonzero;
    logic [LEN_W-1:0] cmd_last_idx;
    logic [REM_W-1:0] cmd_rem;
    logic [REM_W-1:0] rem_sel;
    logic [BYTES-1:0] keep_last;
    logic [LEN_W-1:0] beat_idx_inc;
    logic             next_is_last;

    assign cmd_fire     = cmd_ready_q & axis.cmd_valid;
    assign beat_fire    = tvalid_q & axis.m_axis_tready;
    assign cmd_nonzero  = (axis.cmd_len != '0);
    assign cmd_last_idx = (axis.cmd_len - LEN_W'(1)) >> LOG2B;
    assign beat_idx_inc = beat_idx_q + LEN_W'(1);
    assign next_is_last = (beat_idx_inc == last_idx_q);

    generate
        if (LOG2B > 0) begin : g_rem
            assign cmd_rem = axis.cmd_len[REM_W-1:0];
        end else begin : g_rem_none
            assign cmd_rem = '0;
        end
    endgenerate

    // In IDLE the mask is needed for a possible single-beat command; later
    // it comes from the remainder latched at command accept.
    assign rem_sel = (state_q == ST_IDLE) ? cmd_rem : rem_q;

    axis_keep_mask #(
        .BYTES (BYTES),
        .REM_W (REM_W)
    ) u_keep_mask (
        .rem  (rem_sel),
        .keep (keep_last)
    );

    // State and registered outputs; reset wins over any handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            beat_idx_q  <= '0;
            last_idx_q  <= '0;
            rem_q       <= '0;
            gap_cnt_q   <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            beat_idx_q  <= beat_idx_nxt;
            last_idx_q  <= last_idx_nxt;
            rem_q       <= rem_nxt;
            gap_cnt_q   <= gap_cnt_nxt;
            tvalid_q    <= tvalid_nxt;
            tdata_q     <= tdata_nxt;
            tkeep_q     <= tkeep_nxt;
            tlast_q     <= tlast_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && cmd_nonzero) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_fire && tlast_q) begin
                    state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the beat datapath, counters and registered outputs.
    always_comb begin
        beat_idx_nxt = beat_idx_q;
        last_idx_nxt = last_idx_q;
        rem_nxt      = rem_q;
        gap_cnt_nxt  = gap_cnt_q;
        tvalid_nxt   = tvalid_q;
        tdata_nxt    = tdata_q;
        tkeep_nxt    = tkeep_q;
        tlast_nxt    = tlast_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && cmd_nonzero) begin
                    beat_idx_nxt = '0;
                    last_idx_nxt = cmd_last_idx;
                    rem_nxt      = cmd_rem;
                    tvalid_nxt   = 1'b1;
                    tdata_nxt    = axis.cmd_seed;
                    tlast_nxt    = (cmd_last_idx == '0);
                    tkeep_nxt    = (cmd_last_idx == '0) ? keep_last : '1;
                end
            end
            ST_SEND: begin
                if (beat_fire) begin
                    if (tlast_q) begin
                        tvalid_nxt  = 1'b0;
                        tlast_nxt   = 1'b0;
                        tkeep_nxt   = '0;
                        gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        beat_idx_nxt = beat_idx_inc;
                        tdata_nxt    = tdata_q + WIDTH'(1);
                        tlast_nxt    = next_is_last;
                        tkeep_nxt    = next_is_last ? keep_last : '1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_nxt = gap_cnt_q - GAP_W'(1);
                end
            end
            default: ;
        endcase
        cmd_ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);
    end

    assign axis.cmd_ready     = cmd_ready_q;
    assign axis.m_axis_tvalid = tvalid_q;
    assign axis.m_axis_tdata  = tdata_q;
    assign axis.m_axis_tkeep  = tkeep_q;
    assign axis.m_axis_tlast  = tlast_q;
    assign busy               = busy_q;

`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_beats_q;

    // Packet and beat handshake counters, wrapping at 2^32.
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_pkts_q  <= '0;
            stat_beats_q <= '0;
        end else if (beat_fire) begin
            stat_beats_q <= stat_beats_q + 32'd1;
            if (tlast_q) begin
                stat_pkts_q <= stat_pkts_q + 32'd1;
            end
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_beats = stat_beats_q;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: directed bench for axis_pkt_gen. dut0 uses GAP_CYCLES=0,
// dut1 uses GAP_CYCLES=2. Inputs change 1 ns after the rising edge, outputs
// are sampled at the same point.

module tb_axis_pkt_gen;

    logic aclk;
    logic areset;
    logic busy0, busy1;

    int n_checks;
    int n_fail;

    axis_pkt_gen_if #(.WIDTH(32), .LEN_W(16)) if0 ();
    axis_pkt_gen_if #(.WIDTH(32), .LEN_W(16)) if1 ();

`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] stat_pkts0, stat_beats0, stat_pkts1, stat_beats1;
`endif

    axis_pkt_gen #(.WIDTH(32), .LEN_W(16), .GAP_CYCLES(0)) dut0 (
        .aclk       (aclk),
        .areset     (areset),
        .axis       (if0),
        .busy       (busy0)
`ifdef AXIS_PKT_GEN_STATS_EN
        ,
        .stat_pkts  (stat_pkts0),
        .stat_beats (stat_beats0)
`endif
    );

    axis_pkt_gen #(.WIDTH(32), .LEN_W(16), .GAP_CYCLES(2)) dut1 (
        .aclk       (aclk),
        .areset     (areset),
        .axis       (if1),
        .busy       (busy1)
`ifdef AXIS_PKT_GEN_STATS_EN
        ,
        .stat_pkts  (stat_pkts1),
        .stat_beats (stat_beats1)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end of test, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] len;
        logic [31:0] seed;
        int          n_beats;
        logic [3:0]  last_keep;
        logic [31:0] last_data;
    } pkt_vec_t;

    pkt_vec_t vecs [7];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One packet on dut0 with tready held high, checked beat by beat.
    task automatic run_pkt(input logic [15:0] len, input logic [31:0] seed, input int n,
                           input logic [3:0] lkeep, input logic [31:0] ldata);
        logic [31:0] expd;
        chk("pkt cmd_ready before", 64'(if0.cmd_ready), 64'd1);
        if0.cmd_valid     = 1'b1;
        if0.cmd_len       = len;
        if0.cmd_seed      = seed;
        if0.m_axis_tready = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            expd = seed + 32'(i);
            chk("pkt tvalid", 64'(if0.m_axis_tvalid), 64'd1);
            chk("pkt tdata", 64'(if0.m_axis_tdata), 64'(expd));
            chk("pkt tlast", 64'(if0.m_axis_tlast), 64'(i == n - 1));
            chk("pkt tkeep", 64'(if0.m_axis_tkeep), (i == n - 1) ? 64'(lkeep) : 64'hF);
            if (i == n - 1) chk("pkt last data", 64'(if0.m_axis_tdata), 64'(ldata));
            chk("pkt busy", 64'(busy0), 64'd1);
            tick();
        end
        chk("pkt tvalid after", 64'(if0.m_axis_tvalid), 64'd0);
        chk("pkt cmd_ready after", 64'(if0.cmd_ready), 64'd1);
    endtask

    logic        stall_pat  [6];
    logic [31:0] stall_data [6];
    logic        stall_last [6];
    int          hs;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        areset   = 1'b1;
        if0.cmd_valid = 1'b0; if0.cmd_len = '0; if0.cmd_seed = '0; if0.m_axis_tready = 1'b0;
        if1.cmd_valid = 1'b0; if1.cmd_len = '0; if1.cmd_seed = '0; if1.m_axis_tready = 1'b0;

        vecs[0] = '{16'd10, 32'h0000_0100, 3, 4'b0011, 32'h0000_0102};
        vecs[1] = '{16'd8,  32'hFFFF_FFFF, 2, 4'b1111, 32'h0000_0000};
        vecs[2] = '{16'd1,  32'h0000_00A5, 1, 4'b0001, 32'h0000_00A5};
        vecs[3] = '{16'd4,  32'h0000_0007, 1, 4'b1111, 32'h0000_0007};
        vecs[4] = '{16'd5,  32'h0000_0010, 2, 4'b0001, 32'h0000_0011};
        vecs[5] = '{16'd7,  32'h0000_0000, 2, 4'b0111, 32'h0000_0001};
        vecs[6] = '{16'd17, 32'h0000_0020, 5, 4'b0001, 32'h0000_0024};

        stall_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        stall_data = '{32'h500, 32'h501, 32'h501, 32'h501, 32'h502, 32'h502};
        stall_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset values.
        tick();
        tick();
        chk("rst cmd_ready", 64'(if0.cmd_ready), 64'd1);
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst tvalid", 64'(if0.m_axis_tvalid), 64'd0);
        chk("rst tdata", 64'(if0.m_axis_tdata), 64'd0);
        chk("rst tkeep", 64'(if0.m_axis_tkeep), 64'd0);
        chk("rst tlast", 64'(if0.m_axis_tlast), 64'd0);
        chk("rst gap cmd_ready", 64'(if1.cmd_ready), 64'd1);
        chk("rst gap tvalid", 64'(if1.m_axis_tvalid), 64'd0);
        areset = 1'b0;
        tick();

        // Table-driven packets, back to back.
        for (int v = 0; v < 7; v++) begin
            run_pkt(vecs[v].len, vecs[v].seed, vecs[v].n_beats, vecs[v].last_keep, vecs[v].last_data);
        end

        // Back-pressure: tready 1,0,0,1,0,1 on a 3-beat packet.
        if0.cmd_valid = 1'b1; if0.cmd_len = 16'd12; if0.cmd_seed = 32'h500;
        tick();
        if0.cmd_valid = 1'b0;
        hs = 0;
        for (int k = 0; k < 6; k++) begin
            if0.m_axis_tready = stall_pat[k];
            chk("stall tvalid", 64'(if0.m_axis_tvalid), 64'd1);
            chk("stall tdata", 64'(if0.m_axis_tdata), 64'(stall_data[k]));
            chk("stall tlast", 64'(if0.m_axis_tlast), 64'(stall_last[k]));
            chk("stall tkeep", 64'(if0.m_axis_tkeep), 64'hF);
            if (if0.m_axis_tvalid && if0.m_axis_tready) hs++;
            tick();
        end
        chk("stall handshakes", 64'(hs), 64'd3);
        chk("stall tvalid after", 64'(if0.m_axis_tvalid), 64'd0);
        if0.m_axis_tready = 1'b1;

        // Zero-length command with cmd_valid held, then a 1-byte command.
        areset = 1'b1;
        tick();
        areset = 1'b0;
        if0.cmd_valid = 1'b1; if0.cmd_len = 16'd0; if0.cmd_seed = 32'h66;
        tick();
        chk("zero tvalid", 64'(if0.m_axis_tvalid), 64'd0);
        chk("zero cmd_ready", 64'(if0.cmd_ready), 64'd1);
        chk("zero busy", 64'(busy0), 64'd0);
        if0.cmd_len = 16'd1; if0.cmd_seed = 32'h77;
        tick();
        if0.cmd_valid = 1'b0;
        chk("one tvalid", 64'(if0.m_axis_tvalid), 64'd1);
        chk("one tdata", 64'(if0.m_axis_tdata), 64'h77);
        chk("one tkeep", 64'(if0.m_axis_tkeep), 64'h1);
        chk("one tlast", 64'(if0.m_axis_tlast), 64'd1);
        tick();
        chk("one tvalid after", 64'(if0.m_axis_tvalid), 64'd0);
`ifdef AXIS_PKT_GEN_STATS_EN
        chk("stat_pkts", 64'(stat_pkts0), 64'd1);
        chk("stat_beats", 64'(stat_beats0), 64'd1);
`endif

        // Reset during beat 1 of a 4-beat packet.
        if0.cmd_valid = 1'b1; if0.cmd_len = 16'd16; if0.cmd_seed = 32'h900;
        tick();
        if0.cmd_valid = 1'b0;
        chk("mid beat0", 64'(if0.m_axis_tdata), 64'h900);
        tick();
        chk("mid beat1", 64'(if0.m_axis_tdata), 64'h901);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("mid rst tvalid", 64'(if0.m_axis_tvalid), 64'd0);
        chk("mid rst cmd_ready", 64'(if0.cmd_ready), 64'd1);
        chk("mid rst busy", 64'(busy0), 64'd0);
        run_pkt(16'd4, 32'h33, 1, 4'b1111, 32'h33);

        // GAP_CYCLES=2 with a second command queued behind the first.
        if1.m_axis_tready = 1'b1;
        if1.cmd_valid = 1'b1; if1.cmd_len = 16'd4; if1.cmd_seed = 32'h40;
        tick();
        if1.cmd_seed = 32'h50;
        chk("gap beat tdata", 64'(if1.m_axis_tdata), 64'h40);
        chk("gap beat tlast", 64'(if1.m_axis_tlast), 64'd1);
        chk("gap cmd_ready in send", 64'(if1.cmd_ready), 64'd0);
        tick();
        chk("gap T+1 cmd_ready", 64'(if1.cmd_ready), 64'd0);
        chk("gap T+1 busy", 64'(busy1), 64'd1);
        chk("gap T+1 tvalid", 64'(if1.m_axis_tvalid), 64'd0);
        tick();
        chk("gap T+2 cmd_ready", 64'(if1.cmd_ready), 64'd0);
        chk("gap T+2 busy", 64'(busy1), 64'd1);
        tick();
        chk("gap T+3 cmd_ready", 64'(if1.cmd_ready), 64'd1);
        chk("gap T+3 busy", 64'(busy1), 64'd0);
        tick();
        if1.cmd_valid = 1'b0;
        chk("gap second tvalid", 64'(if1.m_axis_tvalid), 64'd1);
        chk("gap second tdata", 64'(if1.m_axis_tdata), 64'h50);
        tick();
        chk("gap second done", 64'(if1.m_axis_tvalid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-Stream packet source that turns a one-beat command (byte length + seed) into a framed AXIS packet with correct `tkeep`/`tlast`. It is the transmitting end of our AXIS datapath: it drives the slave port of the stream FIFO and downstream sinks for bring-up, loopback and throughput testing. Data is deterministic (seed plus beat index), so a checker can regenerate the expected data.

## Interface
- `WIDTH`, 32: data width in bits. Must be a multiple of 8 and ≥ 8; `BYTES = WIDTH/8` must be a power of two.
- `LEN_W`, 16: width of the byte-length field.
- `GAP_CYCLES`, 0: idle cycles inserted after each `tlast` handshake.
- Reset policy (decided): one clock; reset is synchronous and active-high.
- `aclk`  in  1  clock; all logic is on the rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_len`  in  `LEN_W`  packet length in bytes.
- `cmd_seed`  in  `WIDTH`  data value of beat 0.
- `m_axis_tvalid`  out  1  AXIS master valid.
- `m_axis_tready`  in  1  AXIS master ready.
- `m_axis_tdata`  out  `WIDTH`  beat data.
- `m_axis_tkeep`  out  `BYTES`  byte enables.
- `m_axis_tlast`  out  1  last beat of the packet.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SEND, GAP.
  - IDLE: `cmd_ready = 1`. A command handshake with `cmd_len != 0` latches len/seed and goes to SEND. A command with `cmd_len == 0` is consumed, produces no beats, and the FSM stays in IDLE.
  - SEND: present beats in order. On a handshake of the `tlast` beat, go to GAP if `GAP_CYCLES > 0`, else to IDLE.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- Beat count `N = ceil(cmd_len / BYTES)`. The beat index counter is `LEN_W` bits wide.
- Beat data: beat i has `tdata = seed + i`, modulo 2^WIDTH (wraps silently).
- `tkeep`:
  - All ones on every beat except the last.
  - On the last beat, the low `cmd_len mod BYTES` bits are set; if that remainder is 0, all ones.
  - Enables are always contiguous from bit 0.
- `tlast` is high only on beat N-1.
- AXIS rules:
  - Once `tvalid` is high it stays high until `tready`.
  - `tdata`/`tkeep`/`tlast` are stable while `tvalid & !tready`.
  - `tvalid` does not depend combinationally on `tready`.
- `cmd_ready` is low in SEND and GAP. Commands presented then are held off, never dropped.

## Timing
- Reset values: `cmd_ready = 1`, `busy = 0`, `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `m_axis_tkeep = 0`, `m_axis_tlast = 0`, state IDLE, all counters 0.
- Outputs are registered.
- Command handshake in cycle C → first beat valid in cycle C+1.
- With `tready` held high, throughput is one beat per cycle and a packet of N beats occupies cycles C+1 .. C+N.
- `tlast` handshake in cycle T → `cmd_ready` high in cycle T+1+`GAP_CYCLES`. With `GAP_CYCLES = 0` this allows back-to-back packets with one idle cycle between them.
- Reset mid-packet: the next cycle has `tvalid = 0`, the FSM is in IDLE and the packet is abandoned. Downstream must be reset in the same cycle.
- Reset has priority over every other event in the same cycle.

## Configuration
- `AXIS_PKT_GEN_STATS_EN` defined: adds two output ports.
  - `stat_pkts`, 32 bits: increments on each `tlast` handshake.
  - `stat_beats`, 32 bits: increments on each beat handshake.
  - Both wrap at 2^32, clear on `areset`, and count 0 for zero-length commands.
- Macro undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package `axis_pkt_pkg` holds:
  - the state enum (IDLE/SEND/GAP);
  - a constant function for `BYTES`;
  - a function returning the last-beat keep mask from `len mod BYTES`.
- One sub-module, `axis_keep_mask`: combinational remainder-to-mask decoder, parameterised by `BYTES`, instantiated once. All other logic stays in `axis_pkt_gen`.

## Test plan
All scenarios use WIDTH=32, LEN_W=16 unless stated.
- `cmd_len=10`, `seed=0x100`, `tready=1` → beats `0x100`/`0x101`/`0x102`, `tkeep` `1111`/`1111`/`0011`, `tlast` only on beat 2; first `tvalid` one cycle after the command handshake.
- `cmd_len=8`, `seed=0xFFFFFFFF` → 2 beats `0xFFFFFFFF`, `0x00000000`; last `tkeep=1111`; `tlast` on beat 1.
- `cmd_len=12` with `tready` toggling 1,0,0,1,0,1 → exactly 3 handshakes; outputs stable across every stall; no duplicated or skipped beat.
- `cmd_len=0` while `cmd_valid` held, followed by `cmd_len=1` → first command consumed with no beats; second gives one beat, `tkeep=0001`, `tlast=1`; `stat_pkts=1` when `AXIS_PKT_GEN_STATS_EN` is defined.
- `GAP_CYCLES=2`, two queued commands → `cmd_ready` rises exactly 3 cycles after the first `tlast` handshake; `busy` stays high through GAP.
- `areset` asserted on beat 1 of a 4-beat packet → next cycle `tvalid=0`, `cmd_ready=1`; a fresh command then starts at beat 0 with its own seed.
